// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the 7-segment scan controller.
// Phase encoding, segment width and counter-width helper.
package seg_scan_ctrl_pkg;

   localparam int unsigned SEG_W = 7;
   localparam int unsigned NIB_W = 4;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // All segments dark at the pins, honouring the output polarity.
   function automatic logic [SEG_W-1:0] seg_off(input bit active_low);
      return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   endfunction

   // Bits needed to hold 0..n-1 (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Score-logic side bundle: digit payload, load/enable controls and the
// registered display-pin outputs.
interface seg_scan_ctrl_if
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 4
);
   logic [NIB_W*NUM_DIGITS-1:0] i_digits;
   logic                        i_load;
   logic [NUM_DIGITS-1:0]       i_digit_en;
   logic                        i_lz_suppress;
   logic [SEG_W-1:0]            o_seg;
   logic [NUM_DIGITS-1:0]       o_dig;
   logic                        o_frame_tick;

   modport master (
      output i_digits, i_load, i_digit_en, i_lz_suppress,
      input  o_seg, o_dig, o_frame_tick
   );

   modport slave (
      input  i_digits, i_load, i_digit_en, i_lz_suppress,
      output o_seg, o_dig, o_frame_tick
   );
endinterface

// File: rtl/seg_scan_ctrl_dec.sv
// Hex nibble to 7-segment decoder {g,f,e,d,c,b,a}, active-high font,
// with blanking enable and optional output inversion.
module bin_to_7_seg
   import seg_scan_ctrl_pkg::*;
(
   input  logic [NIB_W-1:0] nib,
   input  logic             en,
   input  logic             inv,
   output logic [SEG_W-1:0] seg_c
);
   logic [SEG_W-1:0] font;

   always_comb begin
      font = 7'h00;
      unique case (nib)
         4'h0: font = 7'h3F;
         4'h1: font = 7'h06;
         4'h2: font = 7'h5B;
         4'h3: font = 7'h4F;
         4'h4: font = 7'h66;
         4'h5: font = 7'h6D;
         4'h6: font = 7'h7D;
         4'h7: font = 7'h07;
         4'h8: font = 7'h7F;
         4'h9: font = 7'h6F;
         4'hA: font = 7'h77;
         4'hB: font = 7'h7C;
         4'hC: font = 7'h39;
         4'hD: font = 7'h5E;
         4'hE: font = 7'h79;
         4'hF: font = 7'h71;
         default: font = 7'h00;
      endcase
   end

   assign seg_c = (en ? font : 7'h00) ^ {SEG_W{inv}};
endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: per-slot blank/show phases,
// frame-aligned digit capture, leading-zero blanking, registered pins.
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned REFRESH_DIV    = 25000,
   parameter int unsigned BLANK_CYCLES   = 64,
   parameter bit          ACTIVE_LOW_SEG = 1'b1,
   parameter bit          ACTIVE_LOW_DIG = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   seg_scan_ctrl_if.slave    bus
);
   localparam int unsigned CNT_W = cnt_w(REFRESH_DIV);
   localparam int unsigned IDX_W = cnt_w(NUM_DIGITS);
   localparam int unsigned DW    = NIB_W * NUM_DIGITS;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   scan_state_e             state, state_n;
   logic [CNT_W-1:0]        cnt, cnt_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [DW-1:0]           act, act_n, pend, pend_n;
   logic                    pend_v, pend_v_n;
   logic [SEG_W-1:0]        seg_q, seg_n;
   logic [NUM_DIGITS-1:0]   dig_q, dig_n;
   logic                    tick_q, tick_n;

   logic                    boundary;
   logic [NUM_DIGITS-1:0]   lzb;
   logic [NUM_DIGITS:0]     nz_above;
   logic [NIB_W-1:0]        nib;
   logic                    dec_en;
   logic [SEG_W-1:0]        dec_seg;
   logic [NUM_DIGITS-1:0]   dig_oh;

   // Leading-zero mask: a digit blanks when it and every higher nibble is zero.
   always_comb begin
      nz_above = '0;
      lzb      = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         nz_above[k] = nz_above[k+1] | (|act[k*NIB_W +: NIB_W]);
         lzb[k]      = (k != 0) && bus.i_lz_suppress && !nz_above[k];
      end
   end

   assign nib    = act[{idx, 2'b00} +: NIB_W];
   assign dec_en = (state == ST_SHOW) && bus.i_digit_en[idx] && !lzb[idx];

   bin_to_7_seg u_dec (
      .nib   (nib),
      .en    (dec_en),
      .inv   (1'(ACTIVE_LOW_SEG)),
      .seg_c (dec_seg)
   );

   assign boundary = (cnt == CNT_LAST) && (idx == IDX_LAST);

   // Next-state, capture and output decode.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt + CNT_W'(1);
      idx_n    = idx;
      act_n    = act;
      pend_n   = pend;
      pend_v_n = pend_v;
      dig_oh   = '0;

      if (cnt == CNT_LAST) begin
         cnt_n = '0;
         idx_n = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      state_n = (cnt_n < CNT_BLANK) ? ST_BLANK : ST_SHOW;

      // Captures only land on act at the frame edge so a frame never tears.
      if (boundary) begin
         if (bus.i_load) begin
            act_n    = bus.i_digits;
            pend_v_n = 1'b0;
         end else if (pend_v) begin
            act_n    = pend;
            pend_v_n = 1'b0;
         end
      end else if (bus.i_load) begin
         pend_n   = bus.i_digits;
         pend_v_n = 1'b1;
      end

      dig_oh[idx] = (state == ST_SHOW);
      dig_n       = ACTIVE_LOW_DIG ? ~dig_oh : dig_oh;
      seg_n       = dec_seg;
      tick_n      = boundary;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state  <= ST_BLANK;
         cnt    <= '0;
         idx    <= '0;
         act    <= '0;
         pend   <= '0;
         pend_v <= 1'b0;
         seg_q  <= seg_off(ACTIVE_LOW_SEG);
         dig_q  <= ACTIVE_LOW_DIG ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
         tick_q <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         idx    <= idx_n;
         act    <= act_n;
         pend   <= pend_n;
         pend_v <= pend_v_n;
         seg_q  <= seg_n;
         dig_q  <= dig_n;
         tick_q <= tick_n;
      end
   end

   assign bus.o_seg        = seg_q;
   assign bus.o_dig        = dig_q;
   assign bus.o_frame_tick = tick_q;
endmodule
